adder_flit_injector: RTL and testbench



---
 rtl/adder_flit_injector.sv | 189 ++++++++++++++++++
 tb/tb_adder_flit_injector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_flit_injector.sv
// +--------------------------------------------------------------------------+
// | adder_flit_injector: LFSR flit packet generator feeding adder operands.   |
// | Optional macro INJ_IDLE_ZERO_EN: drive operands to zero on idle cycles.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module adder_flit_injector #(
  parameter int               N           = 24,
  parameter int               PAYLOAD     = 20,
  parameter int               GAP         = 7,
  parameter int               NUM_PACKETS = 10,
  parameter logic [2*N-1:0]   POLY        = 48'hC000_0018_0000,
  parameter logic [2*N-1:0]   SEED        = 48'h0000_0000_0001
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  output logic [N-1:0]                       input1,
  output logic [N-1:0]                       input2,
  output logic                               valid,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_PACKETS+1)-1:0]   pkt_cnt
);

  localparam int PW = $clog2(NUM_PACKETS + 1);
  localparam int FW = $clog2(PAYLOAD + 1);
  // +2 keeps the gap counter at least one bit wide when GAP is 0
  localparam int GW = $clog2(GAP + 2);

  localparam logic [FW-1:0] C_PAYLOAD  = FW'(PAYLOAD);
  localparam logic [GW-1:0] C_GAP      = GW'(GAP);
  localparam logic [PW-1:0] C_LAST_PKT = PW'(NUM_PACKETS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [2*N-1:0]   r_lfsr;
  logic [N-1:0]     r_input1;
  logic [N-1:0]     r_input2;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_pkt_cnt;
  logic [FW-1:0]    r_flit_cnt;
  logic [GW-1:0]    r_gap_cnt;

  logic             w_load;
  logic             w_seed_load;
  logic             w_valid_nxt;
  logic             w_done_nxt;
  logic [PW-1:0]    w_pkt_nxt;
  logic [FW-1:0]    w_flit_nxt;
  logic [GW-1:0]    w_gap_nxt;
  logic [2*N-1:0]   w_lfsr_src;
  logic [2*N-1:0]   w_flit;

  function automatic logic [2*N-1:0] f_step(input logic [2*N-1:0] x);
    f_step = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_seed_load  = 1'b0;
    w_valid_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    w_pkt_nxt    = r_pkt_cnt;
    w_flit_nxt   = r_flit_cnt;
    w_gap_nxt    = r_gap_cnt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_seed_load  = 1'b1;
          w_valid_nxt  = 1'b1;
          w_flit_nxt   = FW'(1);
          w_pkt_nxt    = '0;
          w_next_state = S_SEND;
        end
      end

      S_SEND: begin
        // Abort wins even on a packet's final flit: that packet is not counted
        if (abort) begin
          w_done_nxt   = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_flit_cnt < C_PAYLOAD) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_flit_nxt  = r_flit_cnt + 1'b1;
        end else begin
          w_pkt_nxt = r_pkt_cnt + 1'b1;
          if (r_pkt_cnt == C_LAST_PKT) begin
            w_done_nxt   = 1'b1;
            w_next_state = S_IDLE;
          end else if (GAP == 0) begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
            w_flit_nxt  = FW'(1);
          end else begin
            w_gap_nxt    = GW'(1);
            w_next_state = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          w_done_nxt   = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_gap_cnt < C_GAP) begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end else begin
          w_load       = 1'b1;
          w_valid_nxt  = 1'b1;
          w_flit_nxt   = FW'(1);
          w_next_state = S_SEND;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_lfsr_src = w_seed_load ? SEED : r_lfsr;
  assign w_flit     = f_step(w_lfsr_src);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr     <= SEED;
      r_input1   <= '0;
      r_input2   <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_busy     <= (w_next_state != S_IDLE);
      r_done     <= w_done_nxt;
      r_pkt_cnt  <= w_pkt_nxt;
      r_flit_cnt <= w_flit_nxt;
      r_gap_cnt  <= w_gap_nxt;
      if (w_load) begin
        r_lfsr   <= w_flit;
        r_input1 <= w_flit[N-1:0];
        r_input2 <= w_flit[2*N-1:N];
      end
`ifdef INJ_IDLE_ZERO_EN
      else begin
        r_input1 <= '0;
        r_input2 <= '0;
      end
`endif
    end
  end

  assign input1  = r_input1;
  assign input2  = r_input2;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pkt_cnt = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adder_flit_injector.sv
// +--------------------------------------------------------------------------+
// | tb_adder_flit_injector: default and GAP=0 instances vs behavioural model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adder_flit_injector;

  localparam logic [47:0] POLY = 48'hC000_0018_0000;
  localparam logic [47:0] SEED = 48'h0000_0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [23:0] a_in1, a_in2, b_in1, b_in2;
  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
  logic [3:0]  a_pkt;
  logic [1:0]  b_pkt;

  adder_flit_injector u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .input1(a_in1), .input2(a_in2), .valid(a_valid), .busy(a_busy),
    .done(a_done), .pkt_cnt(a_pkt)
  );

  adder_flit_injector #(.PAYLOAD(3), .GAP(0), .NUM_PACKETS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .input1(b_in1), .input2(b_in2), .valid(b_valid), .busy(b_busy),
    .done(b_done), .pkt_cnt(b_pkt)
  );

  int errors = 0;
  int checks = 0;
  int vcnt, bcnt, dcnt;

  // flits[i] is the LFSR value after i steps from SEED
  logic [47:0] flits [0:400];
  int cfg_p  [2] = '{20, 3};
  int cfg_g  [2] = '{7, 0};
  int cfg_np [2] = '{10, 2};

  bit          m_run   [2];
  int          m_k     [2];
  logic [47:0] m_op    [2];
  bit          m_valid [2];
  bit          m_busy  [2];
  bit          m_done  [2];
  int          m_pkt   [2];

  function automatic logic [47:0] step48(input logic [47:0] x);
    return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  task automatic idle_ops(input int i);
`ifdef INJ_IDLE_ZERO_EN
    m_op[i] = '0;
`endif
  endtask

  // Output position is derived from cycles since start: packet = k/period
  task automatic model_step(input int i, input bit rn, input bit st, input bit ab);
    int per, total, p, off;
    per   = cfg_p[i] + cfg_g[i];
    total = cfg_np[i] * cfg_p[i] + (cfg_np[i] - 1) * cfg_g[i];
    if (!rn) begin
      m_run[i] = 0; m_op[i] = '0; m_valid[i] = 0; m_busy[i] = 0;
      m_done[i] = 0; m_pkt[i] = 0;
    end else if (!m_run[i]) begin
      m_done[i] = 0;
      if (st) begin
        m_run[i] = 1; m_k[i] = 0; m_pkt[i] = 0;
        m_valid[i] = 1; m_busy[i] = 1; m_op[i] = flits[1];
      end else begin
        m_valid[i] = 0; m_busy[i] = 0; idle_ops(i);
      end
    end else if (ab) begin
      m_run[i] = 0; m_valid[i] = 0; m_busy[i] = 0; m_done[i] = 1; idle_ops(i);
    end else begin
      m_k[i]++;
      m_done[i] = 0;
      if (m_k[i] == total) begin
        m_run[i] = 0; m_valid[i] = 0; m_busy[i] = 0; m_done[i] = 1;
        m_pkt[i] = cfg_np[i]; idle_ops(i);
      end else begin
        p   = m_k[i] / per;
        off = m_k[i] % per;
        m_busy[i]  = 1;
        m_valid[i] = (off < cfg_p[i]);
        m_pkt[i]   = (off >= cfg_p[i]) ? p + 1 : p;
        if (m_valid[i]) m_op[i] = flits[p * cfg_p[i] + off + 1];
        else idle_ops(i);
      end
    end
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a_in1",   a_in1,   m_op[0][23:0]);
    check("a_in2",   a_in2,   m_op[0][47:24]);
    check("a_valid", a_valid, m_valid[0]);
    check("a_busy",  a_busy,  m_busy[0]);
    check("a_done",  a_done,  m_done[0]);
    check("a_pkt",   a_pkt,   m_pkt[0]);
    check("b_in1",   b_in1,   m_op[1][23:0]);
    check("b_in2",   b_in2,   m_op[1][47:24]);
    check("b_valid", b_valid, m_valid[1]);
    check("b_busy",  b_busy,  m_busy[1]);
    check("b_done",  b_done,  m_done[1]);
    check("b_pkt",   b_pkt,   m_pkt[1]);
  endtask

  task automatic cycle(input bit rn, input bit st, input bit ab);
    rst_n = rn; start = st; abort = ab;
    @(posedge clk);
    model_step(0, rn, st, ab);
    model_step(1, rn, st, ab);
    #1;
    compare_all();
    if (a_valid === 1'b1) vcnt++;
    if (a_busy  === 1'b1) bcnt++;
    if (a_done  === 1'b1) dcnt++;
  endtask

  initial begin
    logic [23:0] held1, held2;
    flits[0] = SEED;
    for (int i = 1; i <= 400; i++) flits[i] = step48(flits[i-1]);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;

    // Reset with start held: start must be ignored
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check("rst_valid", a_valid, 0);
    check("rst_in1",   a_in1,   0);
    check("rst_pkt",   a_pkt,   0);
    cycle(1, 0, 0);
    check("idle_after_rst_valid", a_valid, 0);

    // Full default run, with start pulses while busy
    vcnt = 0; bcnt = 0; dcnt = 0;
    cycle(1, 1, 0);
    check("first_in1",   a_in1,   24'h180000);
    check("first_in2",   a_in2,   24'hC00000);
    check("first_valid", a_valid, 1);
    cycle(1, 0, 0);
    check("second_in1", a_in1, 24'h0C0000);
    check("second_in2", a_in2, 24'h600000);
    for (int j = 0; j < 258; j++) cycle(1, ($urandom_range(0, 3) == 0), 0);
    for (int j = 0; j < 10; j++) cycle(1, 0, 0);
    check("run_valid_cycles", vcnt, 200);
    check("run_busy_cycles",  bcnt, 263);
    check("run_done_pulses",  dcnt, 1);
    check("run_pkt_cnt",      a_pkt, 10);

    // GAP=0 instance: 6 back-to-back valid cycles then done
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    for (int j = 0; j < 8; j++) begin
      check("g0_valid", b_valid, (j < 6));
      check("g0_done",  b_done,  (j == 6));
      cycle(1, 0, 0);
    end

    // Abort on the 5th flit of packet 2
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    for (int j = 0; j < 31; j++) cycle(1, 0, 0);
    held1 = a_in1; held2 = a_in2;
    check("pre_abort_in1", a_in1, flits[25][23:0]);
    cycle(1, 0, 1);
    check("abort_valid", a_valid, 0);
    check("abort_done",  a_done,  1);
    check("abort_pkt",   a_pkt,   1);
`ifdef INJ_IDLE_ZERO_EN
    check("abort_in1", a_in1, 0);
    check("abort_in2", a_in2, 0);
`else
    check("abort_in1", a_in1, held1);
    check("abort_in2", a_in2, held2);
`endif
    cycle(1, 0, 0);
    check("abort_done_once", a_done, 0);
    cycle(1, 1, 0);
    check("restart_in1", a_in1, 24'h180000);
    check("restart_in2", a_in2, 24'hC00000);
    check("restart_pkt", a_pkt, 0);

    // Reset during GAP, start alongside reset ignored
    for (int j = 0; j < 21; j++) cycle(1, 0, 0);
    check("gap_valid", a_valid, 0);
    check("gap_busy",  a_busy,  1);
    cycle(0, 1, 0);
    check("gaprst_busy", a_busy, 0);
    check("gaprst_in1",  a_in1,  0);
    check("gaprst_pkt",  a_pkt,  0);
    cycle(1, 0, 0);
    check("gaprst_idle", a_valid, 0);

    // Randomized stimulus
    for (int j = 0; j < 3000; j++)
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
